// File: rtl/axi_slave_responder.sv
// Single-beat AXI4 slave responder.
// AR, AW and W are captured independently into one-deep holding registers.
// A small FSM then performs one 32-bit access at a time on a req/ack backend
// and returns the R or B response. Reads and writes alternate when both are ready.
// Addresses outside the decode window complete with SLVERR and never reach the backend.
module axi_slave_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SIZE_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  // read address channel
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // backend
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_RESP = 3'd2,
    WR_ACC  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] WIN_MASK    = 32'((64'd1 << SIZE_LOG2) - 64'd1);

  state_t      state_q, state_d;
  op_t         last_op_q;
  logic        ready_en_q;
  logic        ar_full_q, aw_full_q, w_full_q;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        ar_len_err_q, aw_len_err_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic wr_rdy, pick_wr, pick_rd;
  logic ar_in_win, aw_in_win;

  // Transfer sizes are informational only: every access is a full word and
  // the strobes pick the bytes.
  logic unused_size;
  assign unused_size = ^{arsize, awsize};

  assign arready = ready_en_q & ~ar_full_q;
  assign awready = ready_en_q & ~aw_full_q;
  assign wready  = ready_en_q & ~w_full_q;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  // Both requests ready: serve the opposite of the last completed operation.
  assign wr_rdy  = aw_full_q & w_full_q;
  assign pick_wr = wr_rdy & (~ar_full_q | (last_op_q == OP_READ));
  assign pick_rd = ar_full_q & ~pick_wr;

  assign ar_in_win = (ar_addr_q & ~WIN_MASK) == BASE_ADDR;
  assign aw_in_win = (aw_addr_q & ~WIN_MASK) == BASE_ADDR;

  // Readys stay low until the first clock edge after reset is released.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Read-address holding register: filled on AR handshake, freed on R handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_full_q    <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_err_q <= 1'b0;
    end else if (ar_hs) begin
      ar_full_q    <= 1'b1;
      ar_addr_q    <= araddr;
      ar_len_err_q <= (arlen != 8'd0);
    end else if (r_hs) begin
      ar_full_q    <= 1'b0;
    end
  end

  // Write-address holding register: filled on AW handshake, freed on B handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q    <= 1'b0;
      aw_addr_q    <= '0;
      aw_len_err_q <= 1'b0;
    end else if (aw_hs) begin
      aw_full_q    <= 1'b1;
      aw_addr_q    <= awaddr;
      aw_len_err_q <= (awlen != 8'd0);
    end else if (b_hs) begin
      aw_full_q    <= 1'b0;
    end
  end

  // Write-data holding register: filled on W handshake, freed on B handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (w_hs) begin
      w_full_q <= 1'b1;
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end else if (b_hs) begin
      w_full_q <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: arbitrate in IDLE, wait for ack, wait for response handshake.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_wr)      state_d = aw_in_win ? WR_ACC : WR_RESP;
        else if (pick_rd) state_d = ar_in_win ? RD_ACC : RD_RESP;
      end
      RD_ACC:  if (mem_ack) state_d = RD_RESP;
      RD_RESP: if (rready)  state_d = IDLE;
      WR_ACC:  if (mem_ack) state_d = WR_RESP;
      WR_RESP: if (bready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: backend request and channel valids decoded from state.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {ar_addr_q[31:2], 2'b00};
    mem_be   = 4'hF;
    rvalid   = 1'b0;
    bvalid   = 1'b0;
    unique case (state_q)
      RD_ACC:  mem_req = 1'b1;
      RD_RESP: rvalid  = 1'b1;
      WR_ACC: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {aw_addr_q[31:2], 2'b00};
        mem_be   = w_strb_q;
      end
      WR_RESP: bvalid  = 1'b1;
      default: ;
    endcase
  end

  // Response payload: set when leaving IDLE for an error or when the backend acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (state_q == IDLE && pick_rd && !ar_in_win) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end else if (state_q == RD_ACC && mem_ack) begin
        rdata_q <= mem_rdata;
        rresp_q <= ar_len_err_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == IDLE && pick_wr && !aw_in_win) begin
        bresp_q <= RESP_SLVERR;
      end else if (state_q == WR_ACC && mem_ack) begin
        bresp_q <= aw_len_err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Alternation memory: records which kind of operation completed last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_op_q <= OP_READ;
    else if (r_hs) last_op_q <= OP_READ;
    else if (b_hs) last_op_q <= OP_WRITE;
  end

  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = rvalid;
  assign bresp     = bresp_q;
  assign mem_wdata = w_data_q;

endmodule
